// File: rtl/apb_timer_unit.sv
// APB timer: 32-bit up-counter with 8-bit prescaler, compare/auto-reload, sticky MATCH flag and level IRQ.
// Optional one-shot mode is built when TIMER_ONESHOT_EN is defined.
module apb_timer_unit #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [APB_DATA_WIDTH-1:0] pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [APB_DATA_WIDTH-1:0] prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      irq_o
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_CMP    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [11:0] offset;
    logic        access;
    logic        addr_ok;
    logic        wr_en;
    logic        rd_en;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_status;
    logic [31:0] wdata;
    logic [31:0] rdata;

    logic        en;
    logic        ie;
    logic        oneshot_bit;
    logic        stop;
    logic [7:0]  presc;
    logic [7:0]  presc_cnt;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        match;
    logic        tick;
    logic        count_hit;
    logic        match_set;

    // The bus node has already selected our range, so only the low 12 bits matter.
    generate
        if (APB_ADDR_WIDTH > 12) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^paddr_i[APB_ADDR_WIDTH-1:12];
        end
    endgenerate

    assign offset  = paddr_i[11:0];
    assign wdata   = pwdata_i[31:0];
    assign access  = psel_i & penable_i;
    assign addr_ok = (offset[11:4] == 8'h00) && (offset[1:0] == 2'b00);

    assign wr_en     = access & pwrite_i & addr_ok;
    assign rd_en     = access & ~pwrite_i & addr_ok;
    assign wr_ctrl   = wr_en && (offset[3:2] == REG_CTRL);
    assign wr_count  = wr_en && (offset[3:2] == REG_COUNT);
    assign wr_cmp    = wr_en && (offset[3:2] == REG_CMP);
    assign wr_status = wr_en && (offset[3:2] == REG_STATUS);

    assign tick      = en && (presc_cnt == presc);
    assign count_hit = (count == cmp);
    // A software COUNT write on a tick cycle suppresses the compare.
    assign match_set = tick & count_hit & ~wr_count;

`ifdef TIMER_ONESHOT_EN
    logic oneshot;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oneshot <= 1'b0;
        end else if (wr_ctrl) begin
            oneshot <= wdata[3];
        end
    end

    assign oneshot_bit = oneshot;
    assign stop        = match_set & oneshot;
`else
    assign oneshot_bit = 1'b0;
    assign stop        = 1'b0;
`endif

    // A CTRL write in the same cycle as a one-shot stop takes priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en <= 1'b0;
        end else if (wr_ctrl) begin
            en <= wdata[0];
        end else if (stop) begin
            en <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ie    <= 1'b0;
            presc <= 8'h00;
        end else if (wr_ctrl) begin
            ie    <= wdata[1];
            presc <= wdata[15:8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_cnt <= 8'h00;
        end else if (wr_ctrl || !en || tick) begin
            presc_cnt <= 8'h00;
        end else begin
            presc_cnt <= presc_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= 32'h0000_0000;
        end else if (wr_count) begin
            count <= wdata;
        end else if (tick) begin
            count <= count_hit ? 32'h0000_0000 : count + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmp <= 32'hFFFF_FFFF;
        end else if (wr_cmp) begin
            cmp <= wdata;
        end
    end

    // Hardware set beats a simultaneous write-one-to-clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            match <= 1'b0;
        end else if (match_set) begin
            match <= 1'b1;
        end else if (wr_status && wdata[0]) begin
            match <= 1'b0;
        end
    end

    always_comb begin
        rdata = 32'h0000_0000;
        if (rd_en) begin
            case (offset[3:2])
                REG_CTRL:   rdata = {16'h0000, presc, 4'h0, oneshot_bit, 1'b0, ie, en};
                REG_COUNT:  rdata = count;
                REG_CMP:    rdata = cmp;
                REG_STATUS: rdata = {31'h0000_0000, match};
                default:    rdata = 32'h0000_0000;
            endcase
        end
    end

    assign prdata_o  = rdata;
    assign pready_o  = 1'b1;
    assign pslverr_o = access & ~addr_ok;
    assign irq_o     = match & ie;

endmodule

// File: tb/tb_apb_timer_unit.sv
// Self-checking bench for apb_timer_unit: closed-form timer model feeds a scoreboard of expected APB responses.
module tb_apb_timer_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] paddr_i = '0;
    logic [31:0] pwdata_i = '0;
    logic        pwrite_i = 1'b0;
    logic        psel_i = 1'b0;
    logic        penable_i = 1'b0;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        irq_o;

    apb_timer_unit #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .paddr_i  (paddr_i),
        .pwdata_i (pwdata_i),
        .pwrite_i (pwrite_i),
        .psel_i   (psel_i),
        .penable_i(penable_i),
        .prdata_o (prdata_o),
        .pready_o (pready_o),
        .pslverr_o(pslverr_o),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    // Model state, rebased at every committed write edge.
    logic        m_en, m_ie, m_os, m_match0;
    logic [31:0] m_cnt0, m_cmp;
    int          m_presc, m_tp, m_tb;

    localparam logic [11:0] A_CTRL = 12'h000;
    localparam logic [11:0] A_COUNT = 12'h004;
    localparam logic [11:0] A_CMP = 12'h008;
    localparam logic [11:0] A_STATUS = 12'h00C;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        m_en = 1'b0; m_ie = 1'b0; m_os = 1'b0; m_match0 = 1'b0;
        m_cnt0 = 32'h0; m_cmp = 32'hFFFF_FFFF; m_presc = 0;
        m_tp = cyc; m_tb = cyc;
    endfunction

    function automatic longint ticks_at(int c);
        if (!m_en || c <= m_tb) return 0;
        return longint'((c - m_tp) / (m_presc + 1) - (m_tb - m_tp) / (m_presc + 1));
    endfunction

    function automatic longint steps_to_match();
        longint c0 = {32'h0, m_cnt0};
        longint cp = {32'h0, m_cmp};
        return (c0 <= cp) ? (cp - c0 + 1) : (64'h1_0000_0000 - c0 + cp + 1);
    endfunction

    function automatic longint eff_ticks(int c);
        longint t = ticks_at(c);
        if (m_os && t > steps_to_match()) t = steps_to_match();
        return t;
    endfunction

    function automatic logic [31:0] model_count(int c);
        longint t = eff_ticks(c);
        longint s = steps_to_match();
        if (t < s) return 32'({32'h0, m_cnt0} + t);
        return 32'((t - s) % ({32'h0, m_cmp} + 1));
    endfunction

    function automatic longint n_match(int c);
        longint t = eff_ticks(c);
        longint s = steps_to_match();
        return (t >= s) ? 1 + (t - s) / ({32'h0, m_cmp} + 1) : 0;
    endfunction

    function automatic logic model_status(int c);
        return m_match0 || (n_match(c) > 0);
    endfunction

    function automatic logic model_en(int c);
        return m_en && !(m_os && ticks_at(c) >= steps_to_match());
    endfunction

    function automatic logic addr_bad(logic [11:0] off);
        return (off[11:4] != 8'h00) || (off[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_read(logic [11:0] off, int c);
        if (addr_bad(off)) return 32'h0;
        case (off[3:2])
            2'd0: return {16'h0, 8'(m_presc), 4'h0, m_os, 1'b0, m_ie, model_en(c)};
            2'd1: return model_count(c);
            2'd2: return m_cmp;
            default: return {31'h0, model_status(c)};
        endcase
    endfunction

    function automatic logic is_match_edge(int e);
        return n_match(e) > n_match(e - 1);
    endfunction

    function automatic void model_write(logic [11:0] off, logic [31:0] data, int w);
        logic [31:0] cnt_now;
        logic        st_now, st_prev, hw, en_now;
        if (addr_bad(off)) return;
        cnt_now = model_count(w);
        st_now  = model_status(w);
        st_prev = model_status(w - 1);
        hw      = is_match_edge(w);
        en_now  = model_en(w);
        m_cnt0 = cnt_now; m_match0 = st_now; m_en = en_now; m_tb = w;
        case (off[3:2])
            2'd0: begin
                m_en = data[0]; m_ie = data[1]; m_presc = int'(data[15:8]); m_tp = w;
`ifdef TIMER_ONESHOT_EN
                m_os = data[3];
`else
                m_os = 1'b0;
`endif
            end
            2'd1: begin m_cnt0 = data; m_match0 = st_prev; end
            2'd2: m_cmp = data;
            default: if (data[0] && !hw) m_match0 = 1'b0;
        endcase
    endfunction

    // Full APB transfer; the expected response is queued when the access phase is driven.
    task automatic applyStimulus(input logic wr, input logic [11:0] off, input logic [31:0] data, input string tag);
        exp_t e;
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
        paddr_i = {20'h1A10B, off}; pwdata_i = data;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        sb_q.push_back('{data: (wr ? 32'h0 : model_read(off, cyc)), err: addr_bad(off)});
        @(negedge clk_i);
        e = sb_q.pop_front();
        checkOutput({tag, "_rdata"}, prdata_o, e.data);
        checkOutput({tag, "_slverr"}, {31'h0, pslverr_o}, {31'h0, e.err});
        checkOutput({tag, "_ready"}, {31'h0, pready_o}, 32'h1);
        @(posedge clk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        if (wr) model_write(off, data, cyc);
    endtask

    task automatic apbWrite(input logic [11:0] off, input logic [31:0] data, input string tag);
        applyStimulus(1'b1, off, data, tag);
    endtask

    task automatic apbRead(input logic [11:0] off, input string tag);
        applyStimulus(1'b0, off, 32'h0, tag);
    endtask

    task automatic checkIrq(input string tag);
        @(negedge clk_i);
        checkOutput(tag, {31'h0, irq_o}, {31'h0, model_status(cyc) & m_ie});
    endtask

    // Wait until edge cyc+ahead is a match edge; a write started now commits at cyc+3.
    task automatic alignMatch(input int ahead);
        bit found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            if (is_match_edge(cyc + ahead)) found = 1'b1;
            else begin @(posedge clk_i); #1; end
        end
        if (!found) checkOutput("align_timeout", 32'h0, 32'h1);
    endtask

    task automatic readAll(input string tag);
        apbRead(A_CTRL, {tag, "_ctrl"});
        apbRead(A_COUNT, {tag, "_count"});
        apbRead(A_CMP, {tag, "_cmp"});
        apbRead(A_STATUS, {tag, "_status"});
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_irq", {31'h0, irq_o}, 32'h0);
        checkOutput("rst_slverr", {31'h0, pslverr_o}, 32'h0);
        checkOutput("rst_ready", {31'h0, pready_o}, 32'h1);
        checkOutput("rst_prdata", prdata_o, 32'h0);
        rst_ni = 1'b1;
        model_reset();
        @(posedge clk_i); #1;
        readAll("reset");

        $display("[TB] periodic match");
        apbWrite(A_CMP, 32'h4, "per_cmp");
        apbWrite(A_CTRL, 32'h3, "per_ctrl");
        for (int i = 0; i < 8; i++) apbRead(A_COUNT, "per_count");
        apbRead(A_STATUS, "per_status");
        checkIrq("per_irq");
        alignMatch(6);
        apbWrite(A_STATUS, 32'h1, "w1c");
        checkIrq("w1c_irq");
        apbRead(A_STATUS, "w1c_status");

        $display("[TB] collisions");
        alignMatch(3);
        apbWrite(A_STATUS, 32'h1, "coll_w1c");
        apbRead(A_STATUS, "coll_w1c_status");
        alignMatch(6);
        apbWrite(A_STATUS, 32'h1, "coll_clr");
        alignMatch(3);
        apbWrite(A_COUNT, 32'h10, "coll_cnt");
        apbRead(A_COUNT, "coll_cnt_count");
        apbRead(A_STATUS, "coll_cnt_status");

        $display("[TB] prescaler");
        apbWrite(A_CTRL, 32'h0, "pre_dis");
        apbWrite(A_COUNT, 32'h0, "pre_cnt");
        apbWrite(A_CMP, 32'h1, "pre_cmp");
        apbWrite(A_STATUS, 32'h1, "pre_clr");
        apbWrite(A_CTRL, 32'h0301, "pre_ctrl");
        for (int i = 0; i < 6; i++) apbRead(A_COUNT, "pre_count");
        apbRead(A_STATUS, "pre_status");
        checkIrq("pre_irq_ie0");
        apbWrite(A_CTRL, 32'h0, "freeze_dis");
        apbRead(A_COUNT, "freeze_count_a");
        repeat (7) @(posedge clk_i);
        #1;
        apbRead(A_COUNT, "freeze_count_b");
        apbRead(A_CTRL, "freeze_ctrl");

        $display("[TB] decode errors");
        apbWrite(12'h010, 32'hDEAD, "err_wr010");
        apbWrite(12'h00A, 32'h1234_5678, "err_wr00A");
        apbRead(12'h006, "err_rd006");
        apbRead(12'hFFC, "err_rdFFC");
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
        paddr_i = {20'h1A10B, A_CMP}; pwdata_i = 32'h0000_1234;
        @(negedge clk_i);
        checkOutput("setup_slverr", {31'h0, pslverr_o}, 32'h0);
        @(posedge clk_i); #1;
        psel_i = 1'b0; pwrite_i = 1'b0;
        readAll("err_after");

        $display("[TB] one-shot control");
        apbWrite(A_COUNT, 32'h0, "os_cnt");
        apbWrite(A_CMP, 32'h2, "os_cmp");
        apbWrite(A_STATUS, 32'h1, "os_clr");
        apbWrite(A_CTRL, 32'hB, "os_ctrl");
        for (int i = 0; i < 6; i++) apbRead(A_COUNT, "os_count");
        apbRead(A_CTRL, "os_ctrl_rd");
        apbRead(A_STATUS, "os_status");
        checkIrq("os_irq");

        $display("[TB] reset during transfer");
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
        paddr_i = {20'h1A10B, A_COUNT}; pwdata_i = 32'h55;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checkOutput("midrst_irq", {31'h0, irq_o}, 32'h0);
        @(posedge clk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        @(posedge clk_i); #1;
        readAll("midrst");
        checkIrq("midrst_irq_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/apb_timer_unit.md
Name: apb_timer_unit

Overview:
- 32-bit APB timer peripheral that fills the timer slot of the peripheral bus; consumes APB transfers routed by the peripheral bus node for the timer address range.
- Free-running up-counter with 8-bit prescaler, compare/auto-reload, sticky match flag and level interrupt to the event unit.
- Zero-wait-state APB slave; the address is decoded on paddr_i[11:0] only, because the bus node has already selected the range.

Parameters:
APB_ADDR_WIDTH, 32, width of paddr_i
APB_DATA_WIDTH, 32, width of pwdata_i/prdata_o; only 32 is supported

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
paddr_i  in  APB_ADDR_WIDTH  APB address
pwdata_i  in  APB_DATA_WIDTH  APB write data
pwrite_i  in  1  1=write, 0=read
psel_i  in  1  APB select
penable_i  in  1  APB enable (access phase)
prdata_o  out  APB_DATA_WIDTH  APB read data
pready_o  out  1  APB ready
pslverr_o  out  1  APB error
irq_o  out  1  timer interrupt, level, active-high

Behaviour:
- Reset (async, rst_ni=0): CTRL=0, COUNT=0, CMP=0xFFFF_FFFF, STATUS=0, prescaler counter=0. Outputs: prdata_o=0, pready_o=1, pslverr_o=0, irq_o=0.
- Register map (byte offset = paddr_i[11:0]):
  - 0x000 CTRL: [0] EN, [1] IE, [3] ONESHOT (see optional feature), [15:8] PRESC. Other bits read 0.
  - 0x004 COUNT: R/W.
  - 0x008 CMP: R/W.
  - 0x00C STATUS: [0] MATCH, sticky; write 1 clears it.
- APB handshake:
  - Access phase = psel_i & penable_i. pready_o is always 1, so every access completes in that one cycle.
  - A write commits on the rising edge that ends the access phase.
  - prdata_o is combinational from the registers during a read access phase and 0 otherwise.
  - Offsets 0x010–0xFFF, or any offset with paddr_i[1:0]≠0: pslverr_o=1 in the access phase only; the write is dropped and prdata_o=0.
  - A setup phase alone (psel_i=1, penable_i=0) has no side effects.
- Prescaler:
  - While EN=1, the 8-bit prescaler counts 0..PRESC, then wraps to 0 and produces a one-cycle tick.
  - Tick period = PRESC+1 cycles; PRESC=0 ticks every cycle.
  - While EN=0 the prescaler is held at 0.
  - Any write to CTRL clears the prescaler, so the first tick after enabling arrives PRESC+1 cycles after the write edge.
- Counter on a tick:
  - If COUNT==CMP: COUNT←0 and MATCH←1.
  - Otherwise COUNT←COUNT+1, wrapping modulo 2^32 (only reachable after a software write puts COUNT above CMP).
- Simultaneous events:
  - A software write to COUNT in the same cycle as a tick: the software value wins and no match is evaluated that cycle.
  - A write to CMP in the same cycle as a tick: the compare uses the old CMP.
  - A W1C of MATCH in the same cycle as a hardware match: the set wins and MATCH stays 1.
- irq_o = MATCH & IE, driven from flops with no extra latency. irq_o rises on the edge after the match tick and stays high until MATCH is cleared or IE=0.
- Clearing EN freezes COUNT and keeps STATUS. Setting EN resumes counting from the current COUNT.
- Reset mid-operation: all state returns to reset values immediately. Any APB transfer in flight is abandoned with no commit.

Optional Feature:
- Macro TIMER_ONESHOT_EN.
- Defined: CTRL[3] ONESHOT is R/W. On a match tick with ONESHOT=1, the same edge sets COUNT←0, MATCH←1 and EN←0, so the timer stops. A CTRL write in that same cycle overrides the auto-clear.
- Undefined: CTRL[3] reads 0, writes to it are ignored, and the timer is always periodic. No ONESHOT logic is synthesized.

Test Plan:
- Reset: hold rst_ni=0, then read all four registers → CTRL=0, COUNT=0, CMP=0xFFFFFFFF, STATUS=0; irq_o=0, pslverr_o=0.
- Periodic match: CMP=4, PRESC=0, CTRL=0x3 → COUNT reads 0,1,2,3,4,0; MATCH=1 and irq_o=1 one edge after the 4→0 tick; writing STATUS=1 clears irq_o on the next edge. The period repeats every 5 cycles.
- Prescaler: PRESC=3, CMP=1, EN=1 → COUNT increments every 4 cycles; first increment 4 cycles after the CTRL write; MATCH is set 8 cycles after the write.
- Collisions: a W1C of STATUS on the match-tick cycle → MATCH stays 1. A COUNT write of 0x10 on a tick cycle → COUNT reads 0x10 and no match that cycle.
- Error/decode: write 0xDEAD to offset 0x010 → pslverr_o=1 for one cycle and no register changes. Read offset 0x006 → pslverr_o=1, prdata_o=0. A setup-only cycle → no write occurs.
- TIMER_ONESHOT_EN defined: CTRL=0xB, CMP=2 → COUNT runs 0,1,2,0 then holds at 0, EN reads 0, MATCH=1. Same test without the macro → CTRL reads 0x3 and counting continues.
